// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: state encoding, default
// frame parameters and a counter-width helper.
package uart_tx_pkg;

    // IDLE/DATA/STOP codes line up with the receiver's state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_SIZE_DEF     = 8;
    localparam int TICKS_PER_BIT_DEF = 1;
    localparam int STOP_BITS_DEF     = 1;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, MSB-first data, stop bit(s), with a one-entry
// holding register so a second word can be queued for zero-gap frames.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS     = DATA_SIZE_DEF,
    parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF,
    parameter int STOP_BITS     = STOP_BITS_DEF
) (
    input  logic                 s_tick,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 tx_start,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int TICK_W = cnt_width(TICKS_PER_BIT - 1);
    localparam int BIT_W  = cnt_width(DATA_BITS - 1);
    localparam int STOP_W = cnt_width(STOP_BITS - 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

    tx_state_e            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [STOP_W-1:0]    r_stop_cnt;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_valid;
    logic                 r_tx;
    logic                 r_done;

    tx_state_e            w_state_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [BIT_W-1:0]     w_bit_cnt_nxt;
    logic [TICK_W-1:0]    w_tick_nxt;
    logic [STOP_W-1:0]    w_stop_cnt_nxt;
    logic [DATA_BITS-1:0] w_hold_nxt;
    logic                 w_hold_valid_nxt;
    logic                 w_tx_nxt;
    logic                 w_done_nxt;
    logic                 w_accept;
    logic                 w_bit_end;
    logic                 w_load_direct;

    assign w_accept  = tx_start & ~r_hold_valid;
    assign w_bit_end = (r_tick_cnt == TICK_LAST);

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_tick_nxt       = r_tick_cnt;
        w_stop_cnt_nxt   = r_stop_cnt;
        w_hold_nxt       = r_hold;
        w_hold_valid_nxt = r_hold_valid;
        w_tx_nxt         = r_tx;
        w_done_nxt       = 1'b0;
        w_load_direct    = 1'b0;

        if (r_state != ST_IDLE) begin
            w_tick_nxt = w_bit_end ? '0 : r_tick_cnt + TICK_W'(1);
        end

        case (r_state)
            ST_IDLE: begin
                w_tick_nxt = '0;
                if (w_accept) begin
                    w_shift_nxt   = din;
                    w_state_nxt   = ST_START;
                    w_tx_nxt      = 1'b0;
                    w_load_direct = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_tx_nxt      = r_shift[DATA_BITS-1];
                    w_state_nxt   = ST_DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == BIT_LAST) begin
                        w_tx_nxt       = 1'b1;
                        w_state_nxt    = ST_STOP;
                        w_stop_cnt_nxt = '0;
                    end else begin
                        w_shift_nxt   = {r_shift[DATA_BITS-2:0], 1'b0};
                        w_tx_nxt      = r_shift[DATA_BITS-2];
                        w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        w_done_nxt = 1'b1;
                        // A held word wins; tx_ready is low then, so no accept can race it.
                        if (r_hold_valid) begin
                            w_shift_nxt      = r_hold;
                            w_hold_valid_nxt = 1'b0;
                            w_state_nxt      = ST_START;
                            w_tx_nxt         = 1'b0;
                        end else if (w_accept) begin
                            w_shift_nxt   = din;
                            w_state_nxt   = ST_START;
                            w_tx_nxt      = 1'b0;
                            w_load_direct = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + STOP_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // Words accepted mid-frame park in the holding register.
        if (w_accept && !w_load_direct) begin
            w_hold_nxt       = din;
            w_hold_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge s_tick) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_tick_cnt   <= '0;
            r_stop_cnt   <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_tx         <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_tick_cnt   <= w_tick_nxt;
            r_stop_cnt   <= w_stop_cnt_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_tx         <= w_tx_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign tx       = r_tx;
    assign tx_ready = ~r_hold_valid;
    assign tx_busy  = (r_state != ST_IDLE);
    assign tx_done  = r_done;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the transmit-side counterpart of the team's `uart_rx` receiver.
- Serialises a parallel byte into start bit, data bits MSB-first and stop bit(s) on line `tx`.
- MSB-first ordering is required because the receiver shift register fills from the LSB side.
- One-entry holding register allows back-to-back frames with no idle gap; the host uses a valid/ready handshake.

Parameters:
- DATA_BITS, 8: data bits per frame; legal 5..8.
- TICKS_PER_BIT, 1: `s_tick` cycles per line bit; legal 1..16. The default 1 pairs with the receiver's one-sample-per-tick timing.
- STOP_BITS, 1: stop bits per frame; legal 1..2.

Ports:
- s_tick  input  1  clock (bit/oversample tick); all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the `s_tick` rising edge.
- din  input  DATA_BITS  byte to send; sampled only on accept.
- tx_start  input  1  host valid; a word is accepted on an edge where `tx_start` && `tx_ready`.
- tx_ready  output  1  holding register empty; `= ~hold_valid`, registered source.
- tx  output  1  serial line, registered; idle high.
- tx_busy  output  1  high whenever state != IDLE.
- tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0. Reset also clears state, shift register, bit counter, tick counter and hold_valid.
- Reset mid-frame: the frame is aborted and the held word is discarded. `tx` is 1 in the cycle after the reset edge; no tx_done pulse.
- States: IDLE, START, DATA, STOP; encoding is 2 bits.
- Tick counter: `tick_cnt` counts 0..TICKS_PER_BIT-1; a bit ends on the edge where `tick_cnt == TICKS_PER_BIT-1`, after which `tick_cnt` wraps to 0.
- IDLE, on accept:
  - Load `din` into the shift register (bypassing hold); the buffer stays empty.
  - state <= START, tx <= 0.
  - Latency: `tx` falls in the cycle immediately after the accept edge.
- START, at bit end: tx <= shift[MSB], state <= DATA, bit_cnt <= 0.
- DATA, at bit end:
  - If bit_cnt == DATA_BITS-1: tx <= 1, state <= STOP, stop_cnt <= 0.
  - Otherwise shift left, tx <= next MSB, bit_cnt += 1.
- STOP, at bit end of the last stop bit:
  - tx_done <= 1 for exactly one cycle.
  - If hold_valid: move hold into the shift register, hold_valid <= 0, state <= START, tx <= 0 (zero-gap back-to-back).
  - Else if accept on this same edge: load `din` directly and go to START.
  - Else: state <= IDLE, tx stays 1.
- Accept while busy (not IDLE): `din` -> hold, hold_valid <= 1, so tx_ready = 0 from the next cycle.
- tx_start while tx_ready=0: ignored; `din` is not captured and no error is flagged.
- Simultaneous accept and hold unload on the final STOP edge: impossible, since tx_ready=0 while hold_valid=1.
- Frame length: (1 + DATA_BITS + STOP_BITS) * TICKS_PER_BIT cycles; default 10 cycles.
- Arithmetic: counters are unsigned and sized by $clog2(max+1), minimum width 1; comparisons are exact equality.

Decomposition:
- Shared header `uart_defs.vh` holds:
  - state localparams IDLE/START/DATA/STOP, shared with `uart_rx` (whose IDLE/DATA/STOP codes match);
  - default DATA_SIZE=8 and default ticks-per-bit.
- No sub-module is required. The holding register is about 10 lines and stays inline; expected RTL is about 150 lines.

Test Plan:
- Single frame: after reset, din=0xA5 with tx_start one cycle. Required:
  - `tx` over the next 10 cycles = 0,1,0,1,0,0,1,0,1,1;
  - tx_done pulses in cycle 10; tx_busy is high cycles 1..10.
  - Loopback into `uart_rx` yields dout=0xA5 with rx_done=1.
- Back-to-back: 0x3C accepted, then 0xC3 accepted one cycle later. Required:
  - tx_ready=0 until the first STOP ends;
  - line bits 0,00111100,1,0,11000011,1 with no idle cycle;
  - two tx_done pulses exactly 10 cycles apart.
- Full-buffer ignore: while sending 0x11 with 0x22 held, pulse tx_start with din=0x33. Required: only 0x11 and 0x22 are transmitted; 0x33 never appears.
- Reset mid-frame: assert reset during DATA bit 4 of 0xFF. Required:
  - tx=1, tx_busy=0, tx_ready=1 the next cycle; no tx_done pulse;
  - a subsequent send of 0x0F is correct.
- Timing parameters: TICKS_PER_BIT=16, STOP_BITS=2, din=0x80. Required:
  - start bit low for 16 cycles, then bit7=1 high for 16 cycles;
  - stop high for 32 cycles; total 176 cycles to tx_done.
- DATA_BITS=5, din=0x15: line = 0,1,0,1,0,1,1; tx_done in cycle 7.
